imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Byte-stream program loader that sits upstream of the CPU's instruction fetch stage.
- Holds the CPU in reset, receives a length-prefixed, XOR-checksummed program image over a valid/ready byte interface, and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port.
- Releases the CPU reset only after a fully verified load.

Parameters:
- ADDR_W, 10, instruction memory word-address width; MAX_WORDS = 2**ADDR_W.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse; begins a new load
- i_byte_valid  input  1  i_byte holds a valid byte
- i_byte  input  8  stream byte
- o_byte_ready  output  1  loader accepts a byte this cycle
- o_imem_we  output  1  instruction memory write strobe (one cycle per word)
- o_imem_addr  output  ADDR_W  word address of the write
- o_imem_wdata  output  32  word written
- o_cpu_rstn  output  1  active-low reset to the CPU (IF/ID/EXE/MEM/WB)
- o_busy  output  1  load in progress
- o_done  output  1  last load verified OK (sticky until next i_start)
- o_err  output  1  last load failed (sticky until next i_start)
- o_word_cnt  output  ADDR_W+1  words written in the current load

Behaviour:
- Reset (async, i_rstn low):
  - State IDLE.
  - All outputs 0, including o_cpu_rstn=0, so the CPU is held in reset.
  - Byte lane, checksum and counters cleared.
- Byte handshake:
  - A byte is accepted on a rising edge with i_byte_valid && o_byte_ready.
  - o_byte_ready is a registered state decode: 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 elsewhere.
  - Gaps in i_byte_valid are allowed at any point.
- States:
  - IDLE / DONE / ERR: i_start moves to LEN_LO. On that edge: clear lane, checksum and o_word_cnt; clear o_done and o_err; set o_busy=1; set o_cpu_rstn=0 (registered, low from the next cycle).
  - i_start in any other state is ignored.
  - LEN_LO: accept the length low byte, then go to LEN_HI.
  - LEN_HI: accept the length high byte; length L = {hi,lo}, 16 bits.
    - L==0 or L>MAX_WORDS: go to ERR.
    - Otherwise: go to DATA.
  - DATA:
    - Bytes fill lanes 0..3, little-endian: word = {b3,b2,b1,b0}.
    - On acceptance of lane 3, o_imem_we=1 in the next cycle, with o_imem_addr = current word index and o_imem_wdata = assembled word.
    - o_word_cnt increments in that same next cycle.
    - Writes are a registered stage, so back-to-back bytes need no stall.
    - After lane 3 of word L-1 is accepted, go to CSUM.
  - CSUM: accept one byte, then compare it with the running checksum.
    - Equal: go to DONE, set o_done=1 and o_cpu_rstn=1, clear o_busy.
    - Not equal: go to ERR, set o_err=1, keep o_cpu_rstn=0, clear o_busy.
  - ERR (from LEN_HI as well): o_err=1, o_busy=0, o_cpu_rstn=0.
- Checksum: XOR of every accepted byte from the length low byte through the last data byte.
- o_imem_we is 0 in every cycle without a completed word. Address and data hold their last values when the strobe is low.
- No write is ever issued outside DATA, and none is issued for a partial word.
- Reset mid-load:
  - Immediate return to IDLE with the CPU held in reset.
  - Partially written memory contents are not scrubbed.
- Restart from DONE:
  - i_start drops o_cpu_rstn in the next cycle.
  - The CPU stays in reset until the new load verifies.

Test Plan:
- Stream 02 00 | 13 00 00 00 | 93 00 10 00 | 92 after i_start, valid held high:
  - Writes addr 0 = 0x00000013, addr 1 = 0x00100093, each a single-cycle strobe one cycle after its 4th byte.
  - o_done=1, o_cpu_rstn=1 one cycle after byte 0x92; o_word_cnt=2.
- Same stream, checksum byte 0x93:
  - Both writes still occur.
  - o_err=1, o_done=0, o_cpu_rstn stays 0.
- Length bytes 00 00:
  - o_err=1 right after the 2nd byte.
  - No o_imem_we; o_byte_ready=0 afterwards.
- ADDR_W=2, length 05 00: ERR after the 2nd byte. Length 04 00 with 16 data bytes and correct checksum: DONE.
- Scenario 1 with i_byte_valid toggling every other cycle, plus an extra i_start pulse mid-DATA: identical writes and result; the extra i_start is ignored.
- Assert i_rstn low after 5 accepted bytes:
  - All outputs reset, with o_cpu_rstn=0.
  - Re-run scenario 1: passes.
  - Then pulse i_start from DONE: o_cpu_rstn=0 on the next cycle, o_done cleared.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Purpose: loads a length-prefixed, XOR-checksummed byte image into instruction memory and holds the CPU in reset until it verifies.
// Latency: each memory write is issued one cycle after the fourth byte of its word; done/err are visible one cycle after the deciding byte.
// Backpressure: o_byte_ready is high in the byte-consuming states; word writes sit in a registered stage, so back-to-back bytes never stall.
module imem_boot_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte,
   output logic              o_byte_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_rstn,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W:0]   o_word_cnt
);

   // 17 bits so that a full 16-bit length can be compared against 2**ADDR_W
   localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [7:0]      len_lo;
   logic [ADDR_W:0] len_words;
   logic [1:0]      lane;
   logic [23:0]     lane_buf;
   logic [7:0]      csum;

   logic            accept;
   logic            start_load;
   logic [16:0]     len_full;
   logic            len_bad;
   logic            last_word;

   assign accept     = i_byte_valid && o_byte_ready;
   assign start_load = i_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   assign len_full   = {1'b0, i_byte, len_lo};
   assign len_bad    = (len_full == 17'd0) || (len_full > MAX_WORDS);
   // o_word_cnt still counts completed words here, so +1 names the word whose lane 3 is arriving
   assign last_word  = (lane == 2'd3) && ((o_word_cnt + ONE_WORD) == len_words);

   // State register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: advance on accepted bytes, start only from a resting state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (i_start) state_nxt = S_LEN_LO;
         S_LEN_LO:              if (accept) state_nxt = S_LEN_HI;
         S_LEN_HI:              if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
         S_DATA:                if (accept && last_word) state_nxt = S_CSUM;
         S_CSUM:                if (accept) state_nxt = (i_byte == csum) ? S_DONE : S_ERR;
         default:               state_nxt = S_IDLE;
      endcase
   end

   // Output decode: the loader takes bytes only in the states that consume the stream
   always_comb begin
      o_byte_ready = 1'b0;
      case (state)
         S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: o_byte_ready = 1'b1;
         default:                            o_byte_ready = 1'b0;
      endcase
   end

   // Datapath: length capture, lane assembly, checksum, write stage and status flags
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         len_lo       <= '0;
         len_words    <= '0;
         lane         <= '0;
         lane_buf     <= '0;
         csum         <= '0;
         o_imem_we    <= 1'b0;
         o_imem_addr  <= '0;
         o_imem_wdata <= '0;
         o_word_cnt   <= '0;
         o_cpu_rstn   <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_imem_we <= 1'b0;
         if (start_load) begin
            lane       <= '0;
            csum       <= '0;
            o_word_cnt <= '0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b1;
            o_cpu_rstn <= 1'b0;
         end
         if (accept) begin
            case (state)
               S_LEN_LO: begin
                  len_lo <= i_byte;
                  csum   <= csum ^ i_byte;
               end
               S_LEN_HI: begin
                  csum      <= csum ^ i_byte;
                  len_words <= len_full[ADDR_W:0];
                  if (len_bad) begin
                     o_err  <= 1'b1;
                     o_busy <= 1'b0;
                  end
               end
               S_DATA: begin
                  csum <= csum ^ i_byte;
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: lane_buf[7:0]   <= i_byte;
                     2'd1: lane_buf[15:8]  <= i_byte;
                     2'd2: lane_buf[23:16] <= i_byte;
                     default: begin
                        o_imem_we    <= 1'b1;
                        o_imem_addr  <= o_word_cnt[ADDR_W-1:0];
                        o_imem_wdata <= {i_byte, lane_buf};
                        o_word_cnt   <= o_word_cnt + ONE_WORD;
                     end
                  endcase
               end
               S_CSUM: begin
                  o_busy <= 1'b0;
                  if (i_byte == csum) begin
                     o_done     <= 1'b1;
                     o_cpu_rstn <= 1'b1;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
